tone_period_meter: RTL and testbench

//   Receive-side counterpart of the buzzer tone path. Samples a square-wave sound input, measures the

---
 rtl/tone_period_meter.sv | 110 +++++++++++
 tb/tb_tone_period_meter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_period_meter.sv
// Measures the half-period of an asynchronous square wave and reports it in the tone generator's
// encoding (half-period cycles - 1). It also flags a stable tone and silence.
module tone_period_meter #(
  parameter int     WIDTH        = 22,
  parameter int     SYNC_STAGES  = 2,
  parameter int     STABLE_COUNT = 4,
  parameter int     TOLERANCE    = 0,
  parameter longint TIMEOUT      = (longint'(1) << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sound_in,
  output logic [WIDTH-1:0] tone_out,
  output logic             tone_valid,
  output logic             locked,
  output logic             silent
);

  localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);
  localparam logic [WIDTH:0]   TOL = (WIDTH+1)'(TOLERANCE);
  localparam logic [3:0]       SC  = 4'(STABLE_COUNT);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

  function automatic logic [3:0] sat_inc_match(input logic [3:0] v);
    return (v >= SC) ? SC : v + 4'd1;
  endfunction

  function automatic logic [WIDTH-1:0] sat_inc_cnt(input logic [WIDTH-1:0] v);
    return (v >= TMO) ? TMO : v + WIDTH'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_prev_p1;
  logic                   edge_p2;

  logic [0:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [3:0]       match_cnt;
  logic             first_ivl;
  logic [WIDTH:0]   diff;
  logic             match;

  // p0/p1: synchronizer and previous-level flop; p2: registered edge strobe (both polarities)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0      <= '0;
      sync_prev_p1 <= 1'b0;
      edge_p2      <= 1'b0;
    end else begin
      sync_p0      <= {sync_p0[SYNC_STAGES-2:0], sound_in};
      sync_prev_p1 <= sync_p0[SYNC_STAGES-1];
      edge_p2      <= sync_p0[SYNC_STAGES-1] ^ sync_prev_p1;
    end
  end

  assign diff  = abs_diff(cnt, tone_out);
  assign match = !first_ivl && (diff <= TOL);

  // p3: interval counter, measurement FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      match_cnt  <= '0;
      first_ivl  <= 1'b1;
      tone_out   <= '0;
      tone_valid <= 1'b0;
      locked     <= 1'b0;
      silent     <= 1'b1;
    end else begin
      tone_valid <= 1'b0;
      cnt        <= edge_p2 ? '0 : sat_inc_cnt(cnt);
      if (state == IDLE) begin
        // The first edge only opens an interval; there is nothing complete to report yet.
        if (edge_p2) begin
          state     <= MEASURE;
          silent    <= 1'b0;
          first_ivl <= 1'b1;
        end
      end else begin
        if (edge_p2) begin
          tone_out   <= cnt;
          tone_valid <= 1'b1;
          first_ivl  <= 1'b0;
          if (match) begin
            match_cnt <= sat_inc_match(match_cnt);
            if (match_cnt == SC) locked <= 1'b1;
          end else begin
            match_cnt <= '0;
            locked    <= 1'b0;
          end
        end else if (cnt == TMO) begin
          state     <= IDLE;
          silent    <= 1'b1;
          locked    <= 1'b0;
          match_cnt <= '0;
        end else if (match_cnt == SC) begin
          locked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_period_meter.sv
// Bench for tone_period_meter: two instances (exact match and tolerance 1) share one stimulus and are
// checked every cycle against a timestamp-based model, plus fixed expectations at key points.
module tb_tone_period_meter;

  localparam int W   = 22;
  localparam int SC  = 4;
  localparam int TMO = 100;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic sound_in = 1'b0;

  logic [W-1:0] tone0, tone1;
  logic         v0, v1, l0, l1, s0, s1;

  always #5 clk = ~clk;

  tone_period_meter #(.WIDTH(W), .SYNC_STAGES(2), .STABLE_COUNT(SC), .TOLERANCE(0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst(rst), .sound_in(sound_in),
    .tone_out(tone0), .tone_valid(v0), .locked(l0), .silent(s0)
  );

  tone_period_meter #(.WIDTH(W), .SYNC_STAGES(2), .STABLE_COUNT(SC), .TOLERANCE(1), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst(rst), .sound_in(sound_in),
    .tone_out(tone1), .tone_valid(v1), .locked(l1), .silent(s1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit jit      = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the sampled input level is delayed by the synchronizer latency, and each
  // instance tracks edge timestamps; tone = cycles between edges - 1.
  int     tol[2] = '{0, 1};
  bit     h0, h1, h2, e_reg;
  longint t = 0;
  bit     m_meas[2], m_have[2], m_valid[2], m_lock[2], m_sil[2];
  int     m_tone[2], m_run[2];
  longint m_last[2];
  bit     set_lock;
  longint ivl;
  longint dlt;

  always @(posedge clk) begin
    t++;
    if (rst) begin
      h0 = 0; h1 = 0; h2 = 0; e_reg = 0;
      for (int i = 0; i < 2; i++) begin
        m_meas[i] = 0; m_have[i] = 0; m_valid[i] = 0; m_lock[i] = 0; m_sil[i] = 1;
        m_tone[i] = 0; m_run[i] = 0; m_last[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        set_lock   = (m_run[i] == SC);
        m_valid[i] = 0;
        if (e_reg) begin
          if (!m_meas[i]) begin
            m_meas[i] = 1; m_sil[i] = 0; m_have[i] = 0;
          end else begin
            ivl = t - m_last[i] - 1;
            if (ivl > TMO) ivl = TMO;
            dlt = ivl - m_tone[i];
            if (dlt < 0) dlt = -dlt;
            if (m_have[i] && dlt <= tol[i]) begin
              if (m_run[i] < SC) m_run[i]++;
            end else begin
              m_run[i] = 0; m_lock[i] = 0; set_lock = 0;
            end
            m_tone[i] = int'(ivl); m_valid[i] = 1; m_have[i] = 1;
          end
          m_last[i] = t;
        end else if (m_meas[i] && (t - m_last[i] - 1) >= TMO) begin
          m_meas[i] = 0; m_sil[i] = 1; m_run[i] = 0; m_lock[i] = 0; set_lock = 0;
        end
        if (set_lock) m_lock[i] = 1;
      end
      e_reg = h1 ^ h2;
      h2 = h1; h1 = h0; h0 = sound_in;
    end
  end

  always @(negedge clk) begin
    chk("tone_out0",  32'(tone0), 32'(m_tone[0]));
    chk("tone_valid0", 32'(v0),   32'(m_valid[0]));
    chk("locked0",    32'(l0),    32'(m_lock[0]));
    chk("silent0",    32'(s0),    32'(m_sil[0]));
    chk("tone_out1",  32'(tone1), 32'(m_tone[1]));
    chk("tone_valid1", 32'(v1),   32'(m_valid[1]));
    chk("locked1",    32'(l1),    32'(m_lock[1]));
    chk("silent1",    32'(s1),    32'(m_sil[1]));
    if (jit && v0) chk("jitter_range0", 32'(tone0 >= 19 && tone0 <= 21), 32'd1);
  end

  // One half-period of a generator running at 'tone'.
  task automatic half(input int tone);
    repeat (tone + 1) @(negedge clk);
    #1 sound_in = ~sound_in;
  endtask

  // Same, but the transition lands at a random sub-cycle offset, possibly past the next clk edge.
  task automatic half_jit(input int tone);
    int d;
    repeat (tone + 1) @(negedge clk);
    d = $urandom_range(1, 8);
    if (d >= 5) d++;
    #d sound_in = ~sound_in;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  int nv;
  int tn, n;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tone", 32'(tone0), 32'd0);
    chk("reset_valid", 32'(v0), 32'd0);
    chk("reset_locked", 32'(l0), 32'd0);
    chk("reset_silent", 32'(s0), 32'd1);
    #1 rst = 1'b0;

    // tone 4 from silence: lock one cycle after the 4th matching interval
    repeat (6) half(4);
    fork
      begin
        repeat (4) @(negedge clk);
        chk("t4_valid", 32'(v0), 32'd1);
        chk("t4_tone", 32'(tone0), 32'd4);
        chk("t4_not_yet_locked", 32'(l0), 32'd0);
        @(negedge clk);
        chk("t4_locked", 32'(l0), 32'd1);
        chk("t4_silent", 32'(s0), 32'd0);
      end
      repeat (10) half(4);
    join

    // tone switch 4 -> 9
    half(9);
    fork
      begin
        repeat (3) @(negedge clk);
        chk("sw_still_locked", 32'(l0), 32'd1);
        @(negedge clk);
        chk("sw_valid", 32'(v0), 32'd1);
        chk("sw_tone", 32'(tone0), 32'd9);
        chk("sw_unlocked", 32'(l0), 32'd0);
      end
      repeat (4) half(9);
    join
    fork
      begin
        repeat (4) @(negedge clk);
        chk("relock_pending", 32'(l0), 32'd0);
        @(negedge clk);
        chk("relock", 32'(l0), 32'd1);
      end
      half(9);
    join

    // tolerance 1: alternating 6/7 locks dut1 only, then 6 -> 8 breaks it
    repeat (5) begin half(6); half(7); end
    fork
      begin
        @(negedge clk);
        chk("tol_locked1", 32'(l1), 32'd1);
        chk("tol_unlocked0", 32'(l0), 32'd0);
      end
      half(6);
    join
    half(8);
    fork
      begin
        repeat (3) @(negedge clk);
        chk("tol_pre_break", 32'(l1), 32'd1);
        @(negedge clk);
        chk("tol_valid8", 32'(v1), 32'd1);
        chk("tol_tone8", 32'(tone1), 32'd8);
        chk("tol_break", 32'(l1), 32'd0);
      end
      half(5);
    join

    // edge coincides with cnt == TIMEOUT: the edge wins
    half(100);
    repeat (4) @(negedge clk);
    chk("tmo_edge_valid", 32'(v0), 32'd1);
    chk("tmo_edge_tone", 32'(tone0), 32'd100);
    chk("tmo_edge_silent", 32'(s0), 32'd0);

    // silence, then first edge gives nothing and the second reports the true interval
    repeat (150) @(negedge clk);
    chk("sil_silent0", 32'(s0), 32'd1);
    chk("sil_locked0", 32'(l0), 32'd0);
    chk("sil_silent1", 32'(s1), 32'd1);
    #1 sound_in = ~sound_in;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      nv += int'(v0);
    end
    chk("sil_first_edge_no_valid", 32'(nv), 32'd0);
    #1 sound_in = ~sound_in;
    repeat (4) @(negedge clk);
    chk("sil_second_valid", 32'(v0), 32'd1);
    chk("sil_second_tone", 32'(tone0), 32'd5);
    half(101);

    // reset mid-interval while locked
    repeat (8) half(4);
    repeat (2) @(negedge clk);
    chk("pre_rst_locked", 32'(l0), 32'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_tone", 32'(tone0), 32'd0);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_locked", 32'(l0), 32'd0);
    chk("rst_silent", 32'(s0), 32'd1);
    #1 rst = 1'b0;
    repeat (6) half(4);

    // jittered tone 20
    half(20);
    half(20);
    jit = 1'b1;
    repeat (30) half_jit(20);
    repeat (6) @(negedge clk);
    jit = 1'b0;

    // randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 4))
        0: begin
          tn = $urandom_range(1, 12);
          n  = $urandom_range(3, 9);
          repeat (n) half(tn);
        end
        1: begin
          tn = $urandom_range(2, 10);
          n  = $urandom_range(4, 10);
          repeat (n) half(tn + $urandom_range(0, 1));
        end
        2: begin
          n = $urandom_range(3, 8);
          repeat (n) half_jit($urandom_range(3, 15));
        end
        3: begin
          repeat ($urandom_range(90, 115)) @(negedge clk);
          #1 sound_in = ~sound_in;
        end
        default: begin
          if ($urandom_range(0, 3) == 0) pulse_rst();
          else half($urandom_range(1, 3));
        end
      endcase
    end

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
